axi4_write_arbiter: RTL

AXI4_WRITE_ARBITER -- requirements
Module: axi4_write_arbiter

---
 rtl/axi4_write_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/axi4_write_arbiter.sv
// Two-requester round-robin arbiter that issues single AXI4-lite write bursts.
// The winner's payload is latched in IDLE and replayed on AW/W until both handshakes finish.
module axi4_write_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req,
  input  logic [2*ADDR_W-1:0]     wr_addr,
  input  logic [2*DATA_W-1:0]     wr_data,
  input  logic [2*DATA_W/8-1:0]   wr_strb,
  output logic [1:0]              done,
  output logic [1:0]              resp,
  output logic [ADDR_W-1:0]       aw_addr,
  output logic                    aw_valid,
  input  logic                    aw_ready,
  output logic [DATA_W-1:0]       w_data,
  output logic [DATA_W/8-1:0]     w_strb,
  output logic                    w_valid,
  input  logic                    w_ready,
  input  logic [1:0]              b_resp,
  input  logic                    b_valid,
  output logic                    b_ready,
  output logic                    busy,
  output logic                    grant_id
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, XFER, RESP, DONE} state_t;

  state_t              state_q, state_d;
  logic                aw_valid_q, aw_valid_d;
  logic                w_valid_q, w_valid_d;
  logic                b_ready_q, b_ready_d;
  logic [1:0]          done_q, done_d;
  logic [1:0]          resp_q, resp_d;
  logic                busy_q, busy_d;
  logic                grant_q, grant_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [STRB_W-1:0]   strb_q, strb_d;

  logic win, aw_hs, w_hs;

  // On a tie the requester not served last wins; otherwise the lone requester.
  assign win   = (req == 2'b11) ? ~last_q : req[1];
  assign aw_hs = aw_valid_q & aw_ready;
  assign w_hs  = w_valid_q & w_ready;

  always_comb begin
    state_d    = state_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_ready_d  = b_ready_q;
    done_d     = '0;
    resp_d     = resp_q;
    grant_d    = grant_q;
    last_d     = last_q;
    addr_d     = addr_q;
    data_d     = data_q;
    strb_d     = strb_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d    = win;
          addr_d     = win ? wr_addr[2*ADDR_W-1:ADDR_W] : wr_addr[ADDR_W-1:0];
          data_d     = win ? wr_data[2*DATA_W-1:DATA_W] : wr_data[DATA_W-1:0];
          strb_d     = win ? wr_strb[2*STRB_W-1:STRB_W] : wr_strb[STRB_W-1:0];
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          state_d    = XFER;
        end
      end
      XFER: begin
        if (aw_hs) aw_valid_d = 1'b0;
        if (w_hs)  w_valid_d  = 1'b0;
        // A channel is finished once its valid has dropped or is handshaking now.
        if ((!aw_valid_q || aw_hs) && (!w_valid_q || w_hs)) begin
          b_ready_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (b_valid) begin
          resp_d          = b_resp;
          b_ready_d       = 1'b0;
          done_d[grant_q] = 1'b1;
          state_d         = DONE;
        end
      end
      DONE: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      done_q     <= '0;
      resp_q     <= '0;
      busy_q     <= 1'b0;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      done_q     <= done_d;
      resp_q     <= resp_d;
      busy_q     <= busy_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
    end
    // Payload registers are only visible behind the valids, so they need no reset.
    addr_q <= addr_d;
    data_q <= data_d;
    strb_q <= strb_d;
  end

  assign aw_addr  = addr_q;
  assign aw_valid = aw_valid_q;
  assign w_data   = data_q;
  assign w_strb   = strb_q;
  assign w_valid  = w_valid_q;
  assign b_ready  = b_ready_q;
  assign done     = done_q;
  assign resp     = resp_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule
